// File: rtl/aes_ct_collector_pkg.sv
// Shared AES definitions: ciphertext block size and output-register state encoding,
// reused by the upstream byte serializer.
package aes_ct_collector_pkg;

  localparam int AES_NBYTES = 16;

  typedef enum logic {
    CT_EMPTY = 1'b0,
    CT_FULL  = 1'b1
  } ct_state_e;

endpackage

// File: rtl/aes_ct_collector.sv
// Assembles byte-serial AES ciphertext MSB-first into blocks and holds each block in a
// double-buffered output register until the consumer takes it; overflow is reported as a sticky flag.
module aes_ct_collector
  import aes_ct_collector_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            d_in,
  input  logic                  d_vld,
  input  logic                  flush,
  output logic [8*NBYTES-1:0]   ct,
  output logic                  ct_vld,
  input  logic                  ct_rdy,
  output logic                  ovf,
  output logic [15:0]           blk_cnt
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  asm_q;
  logic [W-1:0]  asm_nxt;
  logic          cap;
  logic          last;
  ct_state_e     state_q;

  // The completing block includes the byte arriving this cycle, so the output
  // register loads from the next-state view of the shift register.
  assign cap     = d_vld && !flush;
  assign asm_nxt = (asm_q << 8) | W'(d_in);
  assign last    = cap && (cnt_q == CW'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      ct      <= '0;
      ct_vld  <= 1'b0;
      ovf     <= 1'b0;
      blk_cnt <= '0;
      state_q <= CT_EMPTY;
    end else begin
      if (flush) begin
        cnt_q <= '0;
      end else if (d_vld) begin
        asm_q <= asm_nxt;
        cnt_q <= last ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
        CT_EMPTY: begin
          if (last) begin
            ct      <= asm_nxt;
            ct_vld  <= 1'b1;
            state_q <= CT_FULL;
          end
        end
        CT_FULL: begin
          if (ct_rdy) begin
            blk_cnt <= blk_cnt + 16'd1;
            if (last) begin
              ct <= asm_nxt;
            end else begin
              ct_vld  <= 1'b0;
              state_q <= CT_EMPTY;
            end
          end else if (last) begin
            ovf <= 1'b1;
          end
        end
        default: state_q <= CT_EMPTY;
      endcase
    end
  end

endmodule
